// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: FSM encoding, default sizes
// and the gnt-to-result latency of the shared serial divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_M       = 26;
  localparam int DEF_N       = 14;
  localparam int DIV_LAT     = DEF_M + 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int   slot;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[slot]) begin
        found     = 1'b1;
        gnt[slot] = 1'b1;
        idx       = ID_W'(slot);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one external serial divider between NUM_REQ requesters with
// round-robin arbitration. Optional DIV_ZERO_CHECK_EN short-circuits zero divisors.
module divider_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*M-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [M-1:0]         rsp_quotient,
  output logic                 rsp_err,
  output logic                 div_en,
  output logic [M-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [M-1:0]         div_quotient,
  input  logic                 div_ok
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic [M-1:0]        sel_dividend;
  logic [N-1:0]        sel_divisor;
`ifdef DIV_ZERO_CHECK_EN
  logic                zero_pend;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign sel_dividend = req_dividend[int'(arb_idx)*M +: M];
  assign sel_divisor  = req_divisor[int'(arb_idx)*N +: N];

  // RESP arbitrates like IDLE so a waiting request is granted in the cycle after rsp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      id           <= '0;
      gnt          <= '0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_err      <= 1'b0;
      div_en       <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
`ifdef DIV_ZERO_CHECK_EN
      zero_pend    <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
`ifdef DIV_ZERO_CHECK_EN
          if (state == RESP && zero_pend) begin
            zero_pend <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
          end else
`endif
          if (|req) begin
            gnt          <= arb_gnt;
            busy         <= 1'b1;
            id           <= arb_idx;
            ptr          <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
`ifdef DIV_ZERO_CHECK_EN
            if (sel_divisor == '0) begin
              state        <= RESP;
              zero_pend    <= 1'b1;
              rsp_quotient <= '1;
              rsp_err      <= 1'b1;
            end else begin
              state <= LOAD;
            end
`else
            state <= LOAD;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          div_en <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          if (div_ok) begin
            rsp_quotient <= div_quotient;
            rsp_err      <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_id       <= id;
            div_en       <= 1'b0;
            state        <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter with a behavioural restoring divider
// and a scoreboard of expected responses (id, quotient, err, latency).
module tb_divider_arbiter;

  localparam int NR  = 4;
  localparam int M   = 26;
  localparam int N   = 14;
  localparam int IDW = 2;
  localparam int LAT = M + 3;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*M-1:0] req_dividend;
  logic [NR*N-1:0] req_divisor;
  logic [NR-1:0]   gnt;
  logic            busy, rsp_valid, rsp_err, div_en, div_ok;
  logic [IDW-1:0]  rsp_id;
  logic [M-1:0]    rsp_quotient, div_dividend, div_quotient;
  logic [N-1:0]    div_divisor;

  divider_arbiter #(.NUM_REQ(NR), .M(M), .N(N), .ID_W(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .gnt          (gnt),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_err      (rsp_err),
    .div_en       (div_en),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_ok       (div_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural restoring divider: clears while en is low, one quotient bit per cycle, ok after M steps.
  int          dcnt = 0;
  logic [N-1:0] drem = '0;
  logic [N:0]   dtmp;
  always @(posedge clk) begin
    if (!div_en) begin
      dcnt         <= 0;
      div_ok       <= 1'b0;
      div_quotient <= '0;
      drem         <= '0;
    end else if (dcnt == M) begin
      div_ok <= 1'b1;
    end else begin
      dtmp = {drem, div_dividend[M-1-dcnt]};
      if (dtmp >= {1'b0, div_divisor}) begin
        drem         <= N'(dtmp - {1'b0, div_divisor});
        div_quotient <= {div_quotient[M-2:0], 1'b1};
      end else begin
        drem         <= dtmp[N-1:0];
        div_quotient <= {div_quotient[M-2:0], 1'b0};
      end
      dcnt <= dcnt + 1;
    end
  end

  typedef struct {
    int           id;
    logic [M-1:0] q;
    logic         err;
    int           lat;
    int           gcyc;
  } exp_t;

  typedef struct {
    int           id;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic [M-1:0] exp_q;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   rsp_cnt = 0;
  int   rsp_cyc = 0;
  bit   en_seen = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] expDiv(input logic [M-1:0] a, input logic [N-1:0] b);
    if (b == '0) return '1;
    return a / M'(b);
  endfunction

  // Response monitor: every rsp_valid must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (div_en) en_seen = 1'b1;
    if (rsp_valid && !rst) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_rsp: got rsp_id %0d expected no response", rsp_id);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
        checkOutput("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
        checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
        checkOutput("latency", 64'(cyc - e.gcyc), 64'(e.lat));
      end
    end
  end

  task automatic setSlot(input int id, input logic [M-1:0] dvd, input logic [N-1:0] dvs);
    req_dividend[id*M +: M] = dvd;
    req_divisor[id*N +: N]  = dvs;
  endtask

  task automatic pushExp(input int id, input logic [M-1:0] dvd, input logic [N-1:0] dvs, input int gc);
    exp_t e;
    e.id   = id;
    e.q    = expDiv(dvd, dvs);
    e.err  = ZCHK && (dvs == '0);
    e.lat  = (ZCHK && (dvs == '0)) ? 1 : LAT;
    e.gcyc = gc;
    sb.push_back(e);
  endtask

  task automatic waitGnt(output int idx, output int gc, input int budget);
    idx = -1;
    gc  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (|gnt) begin
        checkOutput("gnt_onehot", 64'($onehot(gnt)), 64'd1);
        for (int k = 0; k < NR; k++) if (gnt[k]) idx = k;
        gc = cyc;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL gnt_timeout: got no gnt expected one within %0d cycles", budget);
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    sb.delete();
  endtask

  task automatic applyStimulus(input int id, input logic [M-1:0] dvd, input logic [N-1:0] dvs,
                               input logic [M-1:0] exp_q);
    int idx, gc;
    exp_t e;
    @(negedge clk);
    setSlot(id, dvd, dvs);
    req[id] = 1'b1;
    waitGnt(idx, gc, 10);
    req[id] = 1'b0;
    checkOutput("gnt_idx", 64'(idx), 64'(id));
    e.id   = id;
    e.q    = exp_q;
    e.err  = ZCHK && (dvs == '0);
    e.lat  = (ZCHK && (dvs == '0)) ? 1 : LAT;
    e.gcyc = gc;
    if (idx >= 0) sb.push_back(e);
    waitIdle(100);
  endtask

  vec_t vecs[6];
  int   idx, gc, prev_gc;
  logic [M-1:0] saved_dvd;
  bit   early_gnt, changed;
  int   saved_cnt;

  initial begin
    vecs[0] = '{0, 26'd1000,     14'd7,     26'd142};
    vecs[1] = '{1, 26'h3FFFFFF,  14'd1,     26'h3FFFFFF};
    vecs[2] = '{2, 26'd5,        14'd16383, 26'd0};
    vecs[3] = '{3, 26'd123456,   14'd321,   26'd384};
    vecs[4] = '{1, 26'd50000000, 14'd12345, 26'd4050};
    vecs[5] = '{2, 26'd0,        14'd5,     26'd0};

    rst = 1'b1;
    req = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_gnt", 64'(gnt), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_div_en", 64'(div_en), 64'd0);
    checkOutput("reset_rsp_quotient", 64'(rsp_quotient), 64'd0);
    checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("reset_div_dividend", 64'(div_dividend), 64'd0);
    rst = 1'b0;

    // All four requesting continuously: grants 0,1,2,3,0 spaced M+4 cycles.
    for (int i = 0; i < NR; i++) setSlot(i, M'(1000 * (i + 1) + 17), N'(i + 3));
    req = '1;
    prev_gc = 0;
    for (int k = 0; k < 5; k++) begin
      waitGnt(idx, gc, 40);
      if (idx < 0) break;
      checkOutput("rr_order", 64'(idx), 64'(k % NR));
      if (k > 0) checkOutput("gnt_spacing", 64'(gc - prev_gc), 64'(LAT + 1));
      pushExp(idx, req_dividend[idx*M +: M], req_divisor[idx*N +: N], gc);
      prev_gc = gc;
      if (k == 4) req = '0;
    end
    req = '0;
    waitIdle(200);

    for (int v = 0; v < 6; v++)
      applyStimulus(vecs[v].id, vecs[v].dividend, vecs[v].divisor, vecs[v].exp_q);

    // req[2] arrives mid-RUN of requester 1: no grant and stable operands until the response.
    @(negedge clk);
    setSlot(1, 26'd999999, 14'd37);
    req[1] = 1'b1;
    waitGnt(idx, gc, 10);
    req[1] = 1'b0;
    checkOutput("overlap_gnt1", 64'(idx), 64'd1);
    if (idx >= 0) pushExp(1, 26'd999999, 14'd37, gc);
    saved_dvd = div_dividend;
    repeat (10) @(negedge clk);
    setSlot(2, 26'd300, 14'd4);
    req[2] = 1'b1;
    early_gnt = 1'b0;
    changed   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (|gnt) early_gnt = 1'b1;
      if (div_dividend !== saved_dvd) changed = 1'b1;
    end
    checkOutput("overlap_no_early_gnt", 64'(early_gnt), 64'd0);
    checkOutput("overlap_dividend_stable", 64'(changed), 64'd0);
    waitGnt(idx, gc, 5);
    req[2] = 1'b0;
    checkOutput("overlap_gnt2", 64'(idx), 64'd2);
    checkOutput("overlap_gnt2_timing", 64'(gc - rsp_cyc), 64'd1);
    if (idx >= 0) pushExp(2, 26'd300, 14'd4, gc);
    waitIdle(100);

    // Divide by zero on requester 1.
    en_seen = 1'b0;
    applyStimulus(1, 26'd1000, 14'd0, 26'h3FFFFFF);
    checkOutput("zero_div_en_seen", 64'(en_seen), ZCHK ? 64'd0 : 64'd1);

    // Reset during RUN aborts the operation and returns the pointer to 0.
    @(negedge clk);
    setSlot(1, 26'd5000, 14'd3);
    req[1] = 1'b1;
    waitGnt(idx, gc, 10);
    req[1] = 1'b0;
    checkOutput("abort_gnt", 64'(idx), 64'd1);
    repeat (10) @(negedge clk);
    saved_cnt = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_div_en", 64'(div_en), 64'd0);
    checkOutput("abort_rsp_quotient", 64'(rsp_quotient), 64'd0);
    checkOutput("abort_div_dividend", 64'(div_dividend), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_rsp", 64'(rsp_cnt), 64'(saved_cnt));
    setSlot(0, 26'd777, 14'd7);
    setSlot(3, 26'd4096, 14'd64);
    req[0] = 1'b1;
    req[3] = 1'b1;
    waitGnt(idx, gc, 10);
    req[0] = 1'b0;
    checkOutput("post_reset_ptr0", 64'(idx), 64'd0);
    if (idx >= 0) pushExp(idx, req_dividend[idx*M +: M], req_divisor[idx*N +: N], gc);
    waitGnt(idx, gc, 40);
    req[3] = 1'b0;
    checkOutput("post_reset_gnt3", 64'(idx), 64'd3);
    if (idx >= 0) pushExp(idx, req_dividend[idx*M +: M], req_divisor[idx*N +: N], gc);
    waitIdle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
